// File: rtl/ex_stage_pkg.sv
// Shared encodings for the RV32IM execute stage: ALU op codes, funct3 sub-ops,
// mem_to_reg codes, divider FSM states and one restoring-division step.
package ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_SLL   = 4'h2;
  localparam logic [3:0] ALU_SLT   = 4'h3;
  localparam logic [3:0] ALU_SLTU  = 4'h4;
  localparam logic [3:0] ALU_XOR   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_OR    = 4'h8;
  localparam logic [3:0] ALU_AND   = 4'h9;
  localparam logic [3:0] ALU_MUL   = 4'hA;
  localparam logic [3:0] ALU_PASSB = 4'hB;
  localparam logic [3:0] ALU_DIV   = 4'hE;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // One restoring step: returns {remainder, quotient} after shifting in one bit.
  function automatic logic [63:0] div_step(input logic [31:0] rem,
                                           input logic [31:0] quo,
                                           input logic [31:0] dsr);
    logic [32:0] sh;
    logic        bit_q;
    sh    = {rem, quo[31]};
    bit_q = (sh >= {1'b0, dsr});
    if (bit_q) sh = sh - {1'b0, dsr};
    return {sh[31:0], quo[30:0], bit_q};
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage bundled as one bus.
interface ex_stage_if;
  logic        valid_i;
  logic        flush_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_ext_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] pc_plus_4_i;
  logic [2:0]  funct3_i;
  logic        alu_src_i;
  logic [3:0]  alu_op_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        reg_write_i;
  logic [1:0]  mem_to_reg_i;
  logic        branch_i;
  logic        jump_i;
  logic        jalr_i;

  logic        stall_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] alu_result_o;
  logic [31:0] store_data_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] pc_plus_4_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        reg_write_o;
  logic [1:0]  mem_to_reg_o;

  modport master (
    output valid_i, flush_i, rs1_data_i, rs2_data_i, imm_ext_i, rd_addr_i,
           pc_plus_4_i, funct3_i, alu_src_i, alu_op_i, mem_read_i, mem_write_i,
           reg_write_i, mem_to_reg_i, branch_i, jump_i, jalr_i,
    input  stall_o, redirect_o, redirect_pc_o, alu_result_o, store_data_o,
           rd_addr_o, pc_plus_4_o, mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o
  );

  modport slave (
    input  valid_i, flush_i, rs1_data_i, rs2_data_i, imm_ext_i, rd_addr_i,
           pc_plus_4_i, funct3_i, alu_src_i, alu_op_i, mem_read_i, mem_write_i,
           reg_write_i, mem_to_reg_i, branch_i, jump_i, jalr_i,
    output stall_o, redirect_o, redirect_pc_o, alu_result_o, store_data_o,
           rd_addr_o, pc_plus_4_o, mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o
  );
endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with start/flush/busy/done.
// EX_DIV_RADIX4_EN: retire two quotient bits per BUSY cycle (16 cycles).
module div_unit
  import ex_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  funct3,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy_c,
  output logic        done_c,
  output logic [31:0] result_c
);

`ifdef EX_DIV_RADIX4_EN
  localparam int unsigned BUSY_CYCLES = 16;
`else
  localparam int unsigned BUSY_CYCLES = DIV_CYCLES;
`endif
  localparam int unsigned CNT_W = $clog2(BUSY_CYCLES + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rem_q, quo_q, dsr_q;
  logic             q_neg_q, r_neg_q, is_rem_q;
  logic             start_ok, is_signed, a_neg, b_neg, div_zero, ovf, special;
  logic [31:0]      a_abs, b_abs;
  logic [63:0]      step1, step2;

  assign start_ok  = start & ~flush;
  assign is_signed = ~funct3[0];
  assign a_neg     = is_signed & dividend[31];
  assign b_neg     = is_signed & divisor[31];
  assign a_abs     = a_neg ? 32'(-dividend) : dividend;
  assign b_abs     = b_neg ? 32'(-divisor) : divisor;
  assign div_zero  = (divisor == 32'd0);
  assign ovf       = is_signed & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);
  assign special   = div_zero | ovf;

  assign step1 = div_step(rem_q, quo_q, dsr_q);
`ifdef EX_DIV_RADIX4_EN
  assign step2 = div_step(step1[63:32], step1[31:0], dsr_q);
`else
  assign step2 = step1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start_ok) state_d = special ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: begin
        if (flush)               state_d = DIV_IDLE;
        else if (cnt_q == '0)    state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      DIV_IDLE: busy_c = start_ok;
      DIV_BUSY: busy_c = ~flush;
      DIV_DONE: done_c = 1'b1;
      default:  busy_c = 1'b0;
    endcase
  end

  // Special cases preload the final answer and clear the sign fix-ups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
    end else if (state_q == DIV_IDLE && start_ok) begin
      is_rem_q <= funct3[1];
      dsr_q    <= b_abs;
      cnt_q    <= CNT_W'(BUSY_CYCLES - 1);
      if (special) begin
        quo_q   <= div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        rem_q   <= div_zero ? dividend : 32'd0;
        q_neg_q <= 1'b0;
        r_neg_q <= 1'b0;
      end else begin
        quo_q   <= a_abs;
        rem_q   <= 32'd0;
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
      end
    end else if (state_q == DIV_BUSY) begin
      rem_q <= step2[63:32];
      quo_q <= step2[31:0];
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign result_c = is_rem_q ? (r_neg_q ? 32'(-rem_q) : rem_q)
                             : (q_neg_q ? 32'(-quo_q) : quo_q);

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU/MUL/branch, iterative divide, EX/MEM register.
// EX_DIV_RADIX4_EN selects the two-bits-per-cycle divider.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  ex_stage_if.slave  bus
);

  logic [31:0] op_a, op_b, alu_res, div_result_c, br_target, jalr_target;
  logic [63:0] mul_a, mul_b, prod;
  logic [4:0]  shamt;
  logic        a_sgn, b_sgn, taken, div_busy_c, div_done_c, div_ready, load_ok, redirect_c;

  assign op_a  = bus.rs1_data_i;
  assign op_b  = bus.alu_src_i ? bus.imm_ext_i : bus.rs2_data_i;
  assign shamt = op_b[4:0];

  // Sign-extend per sub-op; the low 64 bits of the wide product are exact.
  assign a_sgn = (bus.funct3_i[1:0] == F3_MULH[1:0]) || (bus.funct3_i[1:0] == F3_MULHSU[1:0]);
  assign b_sgn = (bus.funct3_i[1:0] == F3_MULH[1:0]);
  assign mul_a = {{32{a_sgn & op_a[31]}}, op_a};
  assign mul_b = {{32{b_sgn & op_b[31]}}, op_b};
  assign prod  = mul_a * mul_b;

  div_unit #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (bus.valid_i && bus.alu_op_i == ALU_DIV),
    .flush    (bus.flush_i),
    .funct3   (bus.funct3_i),
    .dividend (op_a),
    .divisor  (op_b),
    .busy_c   (div_busy_c),
    .done_c   (div_done_c),
    .result_c (div_result_c)
  );

  always_comb begin
    alu_res = 32'd0;
    case (bus.alu_op_i)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << shamt;
      ALU_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {31'd0, op_a < op_b};
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_MUL:   alu_res = (bus.funct3_i[1:0] == F3_MUL[1:0]) ? prod[31:0] : prod[63:32];
      ALU_PASSB: alu_res = op_b;
      ALU_DIV:   alu_res = div_result_c;
      default:   alu_res = 32'd0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (bus.funct3_i)
      F3_BEQ:  taken = (bus.rs1_data_i == bus.rs2_data_i);
      F3_BNE:  taken = (bus.rs1_data_i != bus.rs2_data_i);
      F3_BLT:  taken = ($signed(bus.rs1_data_i) <  $signed(bus.rs2_data_i));
      F3_BGE:  taken = ($signed(bus.rs1_data_i) >= $signed(bus.rs2_data_i));
      F3_BLTU: taken = (bus.rs1_data_i <  bus.rs2_data_i);
      F3_BGEU: taken = (bus.rs1_data_i >= bus.rs2_data_i);
      default: taken = 1'b0;
    endcase
  end

  assign br_target   = (bus.pc_plus_4_i - 32'd4) + bus.imm_ext_i;
  assign jalr_target = (bus.rs1_data_i + bus.imm_ext_i) & ~32'd1;

  assign bus.stall_o = div_busy_c;
  assign div_ready   = (bus.alu_op_i != ALU_DIV) | div_done_c;
  assign load_ok     = bus.valid_i & ~bus.flush_i & ~div_busy_c & div_ready;
  assign redirect_c  = load_ok & (bus.jump_i | bus.jalr_i | (bus.branch_i & taken));

  // EX/MEM register; stalls, flushes and invalid slots load a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.redirect_o    <= 1'b0;
      bus.redirect_pc_o <= 32'd0;
      bus.alu_result_o  <= 32'd0;
      bus.store_data_o  <= 32'd0;
      bus.rd_addr_o     <= 5'd0;
      bus.pc_plus_4_o   <= 32'd0;
      bus.mem_read_o    <= 1'b0;
      bus.mem_write_o   <= 1'b0;
      bus.reg_write_o   <= 1'b0;
      bus.mem_to_reg_o  <= 2'd0;
    end else begin
      bus.redirect_o    <= redirect_c;
      bus.redirect_pc_o <= bus.jalr_i ? jalr_target : br_target;
      bus.alu_result_o  <= alu_res;
      bus.store_data_o  <= bus.rs2_data_i;
      bus.rd_addr_o     <= bus.rd_addr_i;
      bus.pc_plus_4_o   <= bus.pc_plus_4_i;
      bus.mem_read_o    <= load_ok & bus.mem_read_i;
      bus.mem_write_o   <= load_ok & bus.mem_write_i;
      bus.reg_write_o   <= load_ok & bus.reg_write_i;
      bus.mem_to_reg_o  <= bus.mem_to_reg_i;
    end
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32IM 5-stage pipeline. Consumes the ID/EX pipeline register contents produced by decode.
- Performs ALU, multiply and branch/jump resolution in one cycle. Performs divide/remainder with an iterative FSM that stalls the front end.
- Owns the EX/MEM pipeline register; all outputs except stall_o are registered.

Parameters:
- DIV_CYCLES, 32, divider iteration count in radix-2 mode (fixed at 16 when EX_DIV_RADIX4_EN is defined).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  ID/EX holds a live instruction
- flush_i  in  1  kill instruction in EX, abort divider
- rs1_data_i  in  32  operand A (already forwarded)
- rs2_data_i  in  32  operand B / store data (already forwarded)
- imm_ext_i  in  32  sign-extended immediate
- rd_addr_i  in  5  destination register
- pc_plus_4_i  in  32  PC+4 of instruction
- funct3_i  in  3  sub-op select for MUL/DIV groups and branch condition
- alu_src_i  in  1  0: B=rs2_data_i, 1: B=imm_ext_i
- alu_op_i  in  4  ALU operation code (package encoding)
- mem_read_i, mem_write_i, reg_write_i  in  1 each  MEM/WB controls
- mem_to_reg_i  in  2  00 ALU, 01 memory, 10 PC+4
- branch_i, jump_i, jalr_i  in  1 each  control flow flags
- stall_o  out  1  combinational; hold IF/ID/EX inputs this cycle
- redirect_o  out  1  registered; taken branch or jump
- redirect_pc_o  out  32  registered target address
- alu_result_o  out  32  EX/MEM result
- store_data_o  out  32  EX/MEM rs2 data
- rd_addr_o  out  5  EX/MEM rd
- pc_plus_4_o  out  32  EX/MEM PC+4
- mem_read_o, mem_write_o, reg_write_o  out  1 each  EX/MEM controls
- mem_to_reg_o  out  2  EX/MEM control

Behaviour:
- Reset: every registered output is 0, divider FSM is IDLE, stall_o=0.
- alu_op encoding (package):
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - A MUL group: funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - B PASSB (LUI)
  - E DIV group: funct3 100 DIV, 101 DIVU, 110 REM, 111 REMU
  - C, D, F reserved; result 0
- Shifts use B[4:0]. MUL is single-cycle combinational with a 64-bit product; sign handling follows the ISA.
- Non-divide ops: EX/MEM register loads on the next rising edge. Latency is 1 cycle.
- Branch conditions are decoded from funct3_i: BEQ, BNE, BLT, BGE, BLTU, BGEU. Both compares use rs1_data_i vs rs2_data_i.
- Branch target is (pc_plus_4_i-4)+imm_ext_i. JAL target is the same. JALR target is (rs1_data_i+imm_ext_i) with bit 0 cleared.
- redirect_o pulses for 1 cycle alongside the EX/MEM load.
- Divider FSM states: IDLE -> BUSY -> DONE -> IDLE.
  - IDLE: on valid_i & alu_op=E & !flush_i, latch operands (absolute values for signed ops), go to BUSY, assert stall_o.
  - BUSY: one restoring step per cycle for DIV_CYCLES cycles, then go to DONE. stall_o=1.
  - DONE: stall_o=0. Result is sign-corrected and loaded into EX/MEM on this edge, then go to IDLE.
- Total stall is DIV_CYCLES+1 cycles. Arrival-to-EX/MEM latency is DIV_CYCLES+2.
- While stall_o=1, EX/MEM loads a bubble: reg_write, mem_read, mem_write and redirect all 0.
- Divide by zero: quotient is 0xFFFFFFFF and remainder is the dividend. DIV overflow (0x80000000 / -1): quotient is 0x80000000 and remainder is 0. Both special cases skip BUSY and go IDLE->DONE, for a 1-cycle stall.
- flush_i: has priority over everything. The FSM returns to IDLE the same edge, stall_o drops combinationally, EX/MEM loads a bubble, and no redirect is issued.
- valid_i=0: EX/MEM loads a bubble.
- Reset asserted mid-divide: the FSM returns to IDLE immediately.

Optional Feature:
- EX_DIV_RADIX4_EN defined: the divider retires 2 quotient bits per cycle. BUSY lasts 16 cycles and the total stall is 17 cycles. Results are identical.
- Undefined: radix-2, with DIV_CYCLES=32 iterations.

Decomposition:
- Package ex_pkg holds:
  - alu_op codes
  - funct3 sub-op and branch constants
  - mem_to_reg codes
  - divider state enum
- Sub-module div_unit (FSM + datapath; start/flush/busy/done handshake). ALU, multiply and branch logic stay inline.

Test Plan:
- ADD rs1=7, rs2=5, then SUB with imm=-3 (alu_src=1) -> alu_result_o=12 then 10, each 1 cycle after valid_i, stall_o=0.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MUL -> 0x00000001.
- DIV -7/2 -> -3, REM -7/2 -> -1. stall_o high exactly 33 cycles, result in EX/MEM at cycle 34 (17/18 with EX_DIV_RADIX4_EN).
- DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000. Each stalls 1 cycle.
- BEQ equal operands with pc_plus_4=0x104 and imm=0x20 -> redirect_o=1, redirect_pc_o=0x120. JALR rs1=0x201, imm=0 -> 0x200, with pc_plus_4 passed through.
- flush_i at BUSY cycle 10 -> stall_o=0 the same cycle, FSM IDLE, reg_write_o=0. A following ADD completes normally.
